scandoubler_framing: RTL

Timing/framing generator that sits directly upstream of the scandoubler line-doubling stage. It measures the incoming pixel-enable period and line length, and produces everything that stage needs:
- the doubled-rate pixel enable
- write counter, read counter and buffer-half select
- a line-doubled horizontal sync
One instance per scandoubler, in the clk_sys domain.

---
 rtl/scandoubler_framing.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/scandoubler_framing.sv
// scandoubler_framing: timing and framing generator placed ahead of the scandoubler
// line-doubling stage. It measures the source pixel-enable period, produces a
// doubled-rate pixel enable, and generates the write/read counters, the buffer-half
// select and a line-doubled hsync.
//
// Ports:
//   clk_sys     - system clock; all state changes on the rising edge
//   reset_n     - asynchronous active-low reset
//   pe_in       - source pixel enable, one clk_sys pulse per source pixel
//   hs_in       - source hsync, active high, sampled only with pe_in
//   vs_in       - source vsync, registered on pe_in into vs_out
//   pe_out      - doubled-rate pixel enable (pe_in only until locked)
//   hcnt        - write pixel counter, source rate
//   sd_hcnt     - read pixel counter, doubled rate
//   line_toggle - buffer half currently being written
//   hs_sd       - line-doubled hsync, active high
//   vs_out      - vs_in registered on pe_in
//   locked      - pe_in period stable, pe_out running at twice the source rate
module scandoubler_framing #(
   parameter int unsigned HCNT_WIDTH  = 10,
   parameter int unsigned HSCNT_WIDTH = 12,
   parameter int unsigned DIV_WIDTH   = 4
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  pe_in,
   input  logic                  hs_in,
   input  logic                  vs_in,
   output logic                  pe_out,
   output logic [HCNT_WIDTH-1:0] hcnt,
   output logic [HCNT_WIDTH-1:0] sd_hcnt,
   output logic                  line_toggle,
   output logic                  hs_sd,
   output logic                  vs_out,
   output logic                  locked
);

   localparam logic [DIV_WIDTH-1:0]   DivMax    = '1;
   localparam logic [HCNT_WIDTH-1:0]  HcntMax   = '1;
   localparam logic [HCNT_WIDTH-1:0]  GlitchLen = HCNT_WIDTH'(3);

   // Period measurement
   logic [DIV_WIDTH-1:0]   ce_cnt_q, ce_cnt_d;
   logic [DIV_WIDTH-1:0]   period_q, period_d;
   logic                   locked_q, locked_d;
   logic [DIV_WIDTH-1:0]   period_new;
   logic                   half_hit;

   // Write side
   logic                   hs_prev_q, hs_prev_d;
   logic [HCNT_WIDTH-1:0]  hcnt_q, hcnt_d;
   logic                   toggle_q, toggle_d;
   logic                   vs_q, vs_d;
   logic [HSCNT_WIDTH-1:0] hs_max_q, hs_max_d;
   logic [HSCNT_WIDTH-1:0] hs_rise_q, hs_rise_d;
   logic [HSCNT_WIDTH-1:0] hs_fall_q, hs_fall_d;
   // Set by a glitch line so that the matching falling edge is ignored too.
   logic                   skip_fall_q, skip_fall_d;

   // Read side
   logic [HCNT_WIDTH-1:0]  sd_hcnt_q, sd_hcnt_d;
   logic                   hs_sd_q, hs_sd_d;

   logic                   hs_rise_edge;
   logic                   hs_fall_edge;
   logic                   glitch;
   logic [HSCNT_WIDTH-1:0] hcnt_ext;
   logic [HSCNT_WIDTH-1:0] sd_hcnt_ext;

   assign period_new = (ce_cnt_q == DivMax) ? DivMax : ce_cnt_q + DIV_WIDTH'(1);

   // ce_cnt+1 is the number of cycles since the last pe_in; compare one bit wider so the
   // saturated count can never alias onto the half period.
   assign half_hit = (({1'b0, ce_cnt_q} + (DIV_WIDTH + 1)'(1)) ==
                      {2'b00, period_q[DIV_WIDTH-1:1]});

   assign pe_out = pe_in | (locked_q & half_hit);

   assign hs_rise_edge = pe_in & hs_in & ~hs_prev_q;
   assign hs_fall_edge = pe_in & ~hs_in & hs_prev_q;
   assign glitch       = (hcnt_q < GlitchLen);
   assign hcnt_ext     = HSCNT_WIDTH'(hcnt_q);
   assign sd_hcnt_ext  = HSCNT_WIDTH'(sd_hcnt_q);

   always_comb begin
      ce_cnt_d    = (ce_cnt_q == DivMax) ? ce_cnt_q : ce_cnt_q + DIV_WIDTH'(1);
      period_d    = period_q;
      locked_d    = locked_q;
      hs_prev_d   = hs_prev_q;
      hcnt_d      = hcnt_q;
      toggle_d    = toggle_q;
      vs_d        = vs_q;
      hs_max_d    = hs_max_q;
      hs_rise_d   = hs_rise_q;
      hs_fall_d   = hs_fall_q;
      skip_fall_d = skip_fall_q;
      sd_hcnt_d   = sd_hcnt_q;
      hs_sd_d     = hs_sd_q;

      if (pe_in) begin
         ce_cnt_d  = '0;
         period_d  = period_new;
         locked_d  = (period_new == period_q) && (period_new >= DIV_WIDTH'(2));
         hs_prev_d = hs_in;
         vs_d      = vs_in;
         if (hs_rise_edge) begin
            hcnt_d   = '0;
            toggle_d = ~toggle_q;
            if (glitch) begin
               skip_fall_d = 1'b1;
            end else begin
               hs_max_d    = hcnt_ext;
               hs_rise_d   = hcnt_ext;
               skip_fall_d = 1'b0;
            end
         end else begin
            if (hs_fall_edge && !skip_fall_q) begin
               hs_fall_d = hcnt_ext;
            end
            // Saturate so a missing hsync never wraps the write address.
            hcnt_d = (hcnt_q == HcntMax) ? hcnt_q : hcnt_q + HCNT_WIDTH'(1);
         end
      end

      // A new source line restarts the read pass regardless of where it was.
      if (hs_rise_edge) begin
         sd_hcnt_d = '0;
      end else if (pe_out) begin
         if (sd_hcnt_ext == hs_max_q) begin
            sd_hcnt_d = '0;
         end else if (sd_hcnt_q != HcntMax) begin
            sd_hcnt_d = sd_hcnt_q + HCNT_WIDTH'(1);
         end
         // Fall checked first so coincident rise/fall positions keep hs_sd low.
         if (sd_hcnt_ext == hs_fall_q) begin
            hs_sd_d = 1'b0;
         end else if (sd_hcnt_ext == hs_rise_q) begin
            hs_sd_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ce_cnt_q    <= '0;
         period_q    <= '0;
         locked_q    <= 1'b0;
         hs_prev_q   <= 1'b0;
         hcnt_q      <= '0;
         toggle_q    <= 1'b0;
         vs_q        <= 1'b0;
         hs_max_q    <= '1;
         hs_rise_q   <= '0;
         hs_fall_q   <= '0;
         skip_fall_q <= 1'b0;
         sd_hcnt_q   <= '0;
         hs_sd_q     <= 1'b0;
      end else begin
         ce_cnt_q    <= ce_cnt_d;
         period_q    <= period_d;
         locked_q    <= locked_d;
         hs_prev_q   <= hs_prev_d;
         hcnt_q      <= hcnt_d;
         toggle_q    <= toggle_d;
         vs_q        <= vs_d;
         hs_max_q    <= hs_max_d;
         hs_rise_q   <= hs_rise_d;
         hs_fall_q   <= hs_fall_d;
         skip_fall_q <= skip_fall_d;
         sd_hcnt_q   <= sd_hcnt_d;
         hs_sd_q     <= hs_sd_d;
      end
   end

   assign hcnt        = hcnt_q;
   assign sd_hcnt     = sd_hcnt_q;
   assign line_toggle = toggle_q;
   assign hs_sd       = hs_sd_q;
   assign vs_out      = vs_q;
   assign locked      = locked_q;

endmodule
